// File: rtl/fft256_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: bit-reversed load, per-stage butterfly
// address/twiddle generation with delayed write-back, and natural-order unload.
module fft256_seq_ctrl #(
  parameter int LOG2N  = 8,
  parameter int BF_LAT = 4,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sop_in,
  input  logic             inv_in,
  output logic             load_we,
  output logic [LOG2N-1:0] load_addr,
  output logic             bf_rd_en,
  output logic [LOG2N-1:0] bf_addr_p,
  output logic [LOG2N-1:0] bf_addr_q,
  output logic [LOG2N-2:0] tw_idx,
  output logic             tw_conj,
  output logic             bf_wr_en,
  output logic [LOG2N-1:0] bf_wr_addr_p,
  output logic [LOG2N-1:0] bf_wr_addr_q,
  output logic [2:0]       stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr,
  output logic             valid_out,
  output logic             sop_out,
  output logic             busy,
  output logic             err_sop
);

  localparam int N      = 1 << LOG2N;
  localparam int HALF   = N / 2;
  localparam int PERIOD = HALF + BF_LAT;
  localparam int CW     = $clog2(PERIOD);

  localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(N - 1);
  localparam logic [CW-1:0]    CYC_LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0]    CYC_ISSUE  = CW'(HALF);
  localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, UNLOAD} state_t;

  state_t           state, next_state;
  logic [LOG2N-1:0] cnt;
  logic [CW-1:0]    cyc;
  logic [2:0]       stage_q;
  logic             tw_conj_q;

  logic             sop_hit, busy_int, accept_idle, calc_issue, stage_end, calc_done;
  logic [LOG2N-1:0] k_ext, mask, j_calc, p_calc, q_calc;
  logic [LOG2N-2:0] tw_calc;

  logic [BF_LAT-1:0] wr_en_sr;
  logic [LOG2N-1:0]  wr_p_sr [BF_LAT];
  logic [LOG2N-1:0]  wr_q_sr [BF_LAT];
  logic [RD_LAT-1:0] rd_sr, sop_sr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // busy stays high until the unload read pipeline has fully drained
  assign sop_hit     = valid_in & sop_in;
  assign busy_int    = (state != IDLE) || (|rd_sr);
  assign accept_idle = (state == IDLE) && sop_hit && !(|rd_sr);
  assign calc_issue  = (state == CALC) && (cyc < CYC_ISSUE);
  assign stage_end   = (state == CALC) && (cyc == CYC_LAST);
  assign calc_done   = stage_end && (stage_q == STAGE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept_idle) next_state = LOAD;
      LOAD:    if (valid_in && !sop_in && cnt == CNT_LAST) next_state = CALC;
      CALC:    if (calc_done) next_state = UNLOAD;
      UNLOAD:  if (cnt == CNT_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cnt serves both load and unload; it wraps to 0 on its own at each boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cyc       <= '0;
      stage_q   <= '0;
      tw_conj_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_idle) begin
            cnt       <= LOG2N'(1);
            tw_conj_q <= inv_in;
          end
        end
        LOAD: begin
          if (valid_in) begin
            if (sop_in) begin
              cnt       <= LOG2N'(1);
              tw_conj_q <= inv_in;
            end else begin
              cnt <= cnt + LOG2N'(1);
            end
          end
        end
        CALC: begin
          if (stage_end) begin
            cyc     <= '0;
            stage_q <= calc_done ? 3'd0 : stage_q + 3'd1;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        UNLOAD:  cnt <= cnt + LOG2N'(1);
        default: ;
      endcase
    end
  end

  // p inserts a zero bit at position stage into k; q is its partner one span away
  always_comb begin
    k_ext   = LOG2N'(cyc[LOG2N-2:0]);
    mask    = (LOG2N'(1) << stage_q) - LOG2N'(1);
    j_calc  = k_ext & mask;
    p_calc  = ((k_ext >> stage_q) << ({1'b0, stage_q} + 4'd1)) | j_calc;
    q_calc  = p_calc | (LOG2N'(1) << stage_q);
    tw_calc = (LOG2N-1)'(j_calc << (STAGE_LAST - stage_q));
  end

  always_comb begin
    load_we   = 1'b0;
    load_addr = '0;
    bf_rd_en  = 1'b0;
    bf_addr_p = '0;
    bf_addr_q = '0;
    tw_idx    = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    unique case (state)
      IDLE: if (accept_idle) load_we = 1'b1;
      LOAD: begin
        if (valid_in) begin
          load_we   = 1'b1;
          load_addr = sop_in ? '0 : bitrev(cnt);
        end
      end
      CALC: begin
        if (calc_issue) begin
          bf_rd_en  = 1'b1;
          bf_addr_p = p_calc;
          bf_addr_q = q_calc;
          tw_idx    = tw_calc;
        end
      end
      UNLOAD: begin
        rd_en   = 1'b1;
        rd_addr = cnt;
      end
      default: ;
    endcase
  end

  // Write-back mirrors the read side BF_LAT cycles later and drains in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_sr <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        wr_p_sr[i] <= '0;
        wr_q_sr[i] <= '0;
      end
    end else begin
      wr_en_sr[0] <= bf_rd_en;
      wr_p_sr[0]  <= bf_addr_p;
      wr_q_sr[0]  <= bf_addr_q;
      for (int i = 1; i < BF_LAT; i++) begin
        wr_en_sr[i] <= wr_en_sr[i-1];
        wr_p_sr[i]  <= wr_p_sr[i-1];
        wr_q_sr[i]  <= wr_q_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sr  <= '0;
      sop_sr <= '0;
    end else begin
      rd_sr[0]  <= rd_en;
      sop_sr[0] <= rd_en && (rd_addr == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        rd_sr[i]  <= rd_sr[i-1];
        sop_sr[i] <= sop_sr[i-1];
      end
    end
  end

  assign bf_wr_en     = wr_en_sr[BF_LAT-1];
  assign bf_wr_addr_p = wr_p_sr[BF_LAT-1];
  assign bf_wr_addr_q = wr_q_sr[BF_LAT-1];
  assign valid_out    = rd_sr[RD_LAT-1];
  assign sop_out      = sop_sr[RD_LAT-1];
  assign stage        = stage_q;
  assign tw_conj      = tw_conj_q;
  assign busy         = busy_int;
  assign err_sop      = sop_hit && busy_int && (state != LOAD);

endmodule
